packet_sender: RTL and testbench

Framed memory-to-UART transmit stage. On a start pulse from the main FSM it reads FRAME_LEN sampled bytes from the sample memory and streams them through the UART transmit handshake, one byte at a time. Each frame is wrapped with a sync byte, a 16-bit length, and an optional checksum, so the PC side can resynchronise on the stream. It sits between the sample memory read port and the UART CSR write port, in the slot the plain unframed sender occupies.

---
 rtl/packet_sender.sv | 145 ++++++++++++++
 tb/tb_packet_sender.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_sender.sv
// Framed memory-to-UART transmit stage: SYNC, LEN_HI, LEN_LO, FRAME_LEN data bytes and an optional checksum.
// Define PACKET_SENDER_CHECKSUM_EN to append the 8-bit CHK byte; otherwise frames end after the last data byte.
module packet_sender #(
    parameter int unsigned FRAME_LEN = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iStartSignal,
    input  logic        iTxDone,
    input  logic [7:0]  iMemData,
    output logic [15:0] oAddress,
    output logic [7:0]  oTxData,
    output logic        oTxSend,
    output logic        oBusy,
    output logic        oFinished,
    output logic [2:0]  state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_LOAD  = 3'd4;
`ifdef PACKET_SENDER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd5;
`endif
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [15:0] LEN = 16'(FRAME_LEN);

    logic [1:0]  hdr_cnt;
    logic [15:0] idx;
    logic [7:0]  tx_hold;
    logic [7:0]  hdr_byte;
`ifdef PACKET_SENDER_CHECKSUM_EN
    logic [7:0]  chk_sum;
    logic        chk_sent;
`endif

    always_comb begin
        case (hdr_cnt)
            2'd0:    hdr_byte = SYNC_BYTE;
            2'd1:    hdr_byte = LEN[15:8];
            default: hdr_byte = LEN[7:0];
        endcase
    end

    // Send strobes are decoded from the state so the byte leaves one cycle after the triggering edge;
    // in LOAD the memory q is forwarded directly because it only becomes valid in that cycle.
    always_comb begin
        oTxData = tx_hold;
        case (state)
            S_HDR:   oTxData = hdr_byte;
            S_LOAD:  oTxData = iMemData;
`ifdef PACKET_SENDER_CHECKSUM_EN
            S_CHK:   oTxData = chk_sum;
`endif
            default: oTxData = tx_hold;
        endcase
    end

`ifdef PACKET_SENDER_CHECKSUM_EN
    assign oTxSend   = (state == S_HDR) || (state == S_LOAD) || (state == S_CHK);
`else
    assign oTxSend   = (state == S_HDR) || (state == S_LOAD);
`endif
    assign oBusy     = (state != S_IDLE);
    assign oFinished = (state == S_DONE);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state    <= S_IDLE;
            oAddress <= 16'd0;
            idx      <= 16'd0;
            hdr_cnt  <= 2'd0;
            tx_hold  <= 8'd0;
`ifdef PACKET_SENDER_CHECKSUM_EN
            chk_sum  <= 8'd0;
            chk_sent <= 1'b0;
`endif
        end else begin
            if (oTxSend) begin
                tx_hold <= oTxData;
            end
            case (state)
                S_IDLE: begin
                    if (iStartSignal) begin
                        idx      <= 16'd0;
                        oAddress <= 16'd0;
                        hdr_cnt  <= 2'd0;
`ifdef PACKET_SENDER_CHECKSUM_EN
                        chk_sum  <= 8'd0;
                        chk_sent <= 1'b0;
`endif
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    hdr_cnt <= hdr_cnt + 2'd1;
`ifdef PACKET_SENDER_CHECKSUM_EN
                    // SYNC is excluded from the checksum; both length bytes are included.
                    if (hdr_cnt != 2'd0) begin
                        chk_sum <= chk_sum + hdr_byte;
                    end
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (iTxDone) begin
                        if (hdr_cnt != 2'd3) begin
                            state <= S_HDR;
                        end else if (idx != LEN) begin
                            oAddress <= idx;
                            state    <= S_FETCH;
                        end else begin
`ifdef PACKET_SENDER_CHECKSUM_EN
                            state <= chk_sent ? S_DONE : S_CHK;
`else
                            state <= S_DONE;
`endif
                        end
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    idx   <= idx + 16'd1;
`ifdef PACKET_SENDER_CHECKSUM_EN
                    chk_sum <= chk_sum + iMemData;
`endif
                    state <= S_WAIT;
                end
`ifdef PACKET_SENDER_CHECKSUM_EN
                S_CHK: begin
                    chk_sent <= 1'b1;
                    state    <= S_WAIT;
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_sender.sv
// Bench for packet_sender: a 4-byte and a 256-byte frame instance, an auto-responding UART model and a frame-level reference.
module tb_packet_sender;

`ifdef PACKET_SENDER_CHECKSUM_EN
    localparam int N4   = 8;
    localparam int L4   = 8'hA4;
    localparam int N256 = 260;
    localparam int L256 = 8'h81;
    localparam bit CHK_ON = 1'b1;
`else
    localparam int N4   = 7;
    localparam int L4   = 8'h40;
    localparam int N256 = 259;
    localparam int L256 = 8'hFF;
    localparam bit CHK_ON = 1'b0;
`endif

    typedef struct {
        bit big;
        int lat;
        bit noise;
        bit mid_start;
        bit fin_start;
        int kind;
        int exp_bytes;
        int exp_last;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, done, sel;
    logic [15:0] addr_s, addr_b;
    logic [7:0]  data_s, data_b, q_s, q_b;
    logic        send_s, send_b, busy_s, busy_b, fin_s, fin_b;
    logic [2:0]  st_s, st_b;

    logic [7:0] mem [256];

    packet_sender #(.FRAME_LEN(4)) dut_s (
        .iClock(clk), .iReset(rst), .iStartSignal(start & ~sel), .iTxDone(done),
        .iMemData(q_s), .oAddress(addr_s), .oTxData(data_s), .oTxSend(send_s),
        .oBusy(busy_s), .oFinished(fin_s), .state(st_s)
    );

    packet_sender #(.FRAME_LEN(256)) dut_b (
        .iClock(clk), .iReset(rst), .iStartSignal(start & sel), .iTxDone(done),
        .iMemData(q_b), .oAddress(addr_b), .oTxData(data_b), .oTxSend(send_b),
        .oBusy(busy_b), .oFinished(fin_b), .state(st_b)
    );

    // Sample memory with one cycle of read latency.
    always @(posedge clk) begin
        q_s <= mem[addr_s[7:0]];
        q_b <= mem[addr_b[7:0]];
    end

    logic [15:0] obs_addr;
    logic [7:0]  obs_data;
    logic        obs_send, obs_busy, obs_fin;
    assign obs_addr = sel ? addr_b : addr_s;
    assign obs_data = sel ? data_b : data_s;
    assign obs_send = sel ? send_b : send_s;
    assign obs_busy = sel ? busy_b : busy_s;
    assign obs_fin  = sel ? fin_b  : fin_s;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0] got_q[$];
    int         send_cyc_q[$];
    int         addr_q[$];
    logic [7:0] exp_q[$];
    int  dbl_cnt = 0;
    int  fin_cnt = 0;
    int  fin_cyc = 0;
    bit  prev_send = 1'b0;
    bit  prev_fin = 1'b0;
    bit  busy_at_fin = 1'b0;
    bit  busy_after_fin = 1'b1;

    always @(negedge clk) begin
        prev_send <= obs_send;
        prev_fin  <= obs_fin;
        if (obs_send) begin
            got_q.push_back(obs_data);
            send_cyc_q.push_back(cyc);
            addr_q.push_back(int'(obs_addr));
        end
        if (obs_send && prev_send) dbl_cnt <= dbl_cnt + 1;
        if (obs_fin) begin
            fin_cnt     <= fin_cnt + 1;
            fin_cyc     <= cyc;
            busy_at_fin <= obs_busy;
        end
        if (prev_fin) busy_after_fin <= obs_busy;
    end

    // UART model: acknowledges each byte lat cycles after its send; noise adds stray pulses outside WAIT.
    int lat = 20;
    bit noise = 1'b0;
    int real_done_cyc = 0;
    initial begin
        int  cnt;
        bit  stretch;
        logic d;
        cnt = 0;
        stretch = 1'b0;
        done = 1'b0;
        forever begin
            @(negedge clk);
            d = 1'b0;
            if (stretch) begin
                d = noise;
                stretch = 1'b0;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    d = 1'b1;
                    real_done_cyc = cyc;
                    stretch = 1'b1;
                end
            end
            if (obs_send) begin
                cnt = lat;
                if (noise) d = 1'b1;
            end
            done = d;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: sync, 16-bit length, data, then the mod-256 sum of length and data bytes.
    task automatic build_exp(input int n);
        int sum;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'((n >> 8) & 255));
        exp_q.push_back(8'(n & 255));
        sum = (n >> 8) + (n & 255);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[i]);
            sum = sum + int'(mem[i]);
        end
        if (CHK_ON) exp_q.push_back(8'(sum % 256));
    endtask

    task automatic run_frame(input int n, input bit mid, input bit fs, input int exp_bytes, input int exp_last);
        int base, fbase, dbase, t0, guard, ngot, ncmp;
        base  = got_q.size();
        fbase = fin_cnt;
        dbase = dbl_cnt;
        t0    = cyc;
        start = 1'b1;
        guard = 0;
        while (fin_cnt == fbase && guard < 20000) begin
            @(negedge clk);
            guard++;
            start = (mid && guard == 15) || (fs && obs_fin);
        end
        start = 1'b0;
        check("frame_timeout", 32'(guard < 20000), 32'd1);
        repeat (4) @(negedge clk);
        ngot = got_q.size() - base;
        check("byte_count", ngot, exp_bytes);
        ncmp = (ngot < exp_q.size()) ? ngot : exp_q.size();
        for (int i = 0; i < ncmp; i++) check("frame_byte", got_q[base + i], exp_q[i]);
        if (exp_last >= 0 && ngot > 0) check("last_byte", got_q[base + ngot - 1], exp_last);
        if (ngot > 0) check("sync_latency", send_cyc_q[base] - t0, 1);
        if (ngot > 1) check("hdr_spacing", send_cyc_q[base + 1] - send_cyc_q[base], lat + 1);
        for (int i = 0; i < n && 3 + i < ngot; i++) begin
            check("data_addr", addr_q[base + 3 + i], i);
            if (i > 0) check("data_spacing", send_cyc_q[base + 3 + i] - send_cyc_q[base + 2 + i], lat + 2);
        end
        check("finished_count", fin_cnt - fbase, 1);
        check("finished_latency", fin_cyc - real_done_cyc, 1);
        check("busy_at_finished", busy_at_fin, 1'b1);
        check("busy_after_finished", busy_after_fin, 1'b0);
        check("double_send", dbl_cnt - dbase, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   base, sz, guard, fbase;

        vecs[0] = '{1'b0, 20, 1'b0, 1'b0, 1'b0, 0, N4, L4};
        vecs[1] = '{1'b0, 1, 1'b0, 1'b0, 1'b1, 0, N4, L4};
        vecs[2] = '{1'b0, 3, 1'b1, 1'b1, 1'b0, 0, N4, L4};
        vecs[3] = '{1'b1, 2, 1'b0, 1'b0, 1'b0, 1, N256, L256};
        for (int i = 4; i < 7; i++)
            vecs[i] = '{1'b0, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 2, N4, -1};

        rst = 1'b1;
        start = 1'b0;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr_s", addr_s, 0);
        check("rst_data_s", data_s, 0);
        check("rst_send_s", send_s, 0);
        check("rst_busy_s", busy_s, 0);
        check("rst_fin_s", fin_s, 0);
        check("rst_addr_b", addr_b, 0);
        check("rst_send_b", send_b, 0);
        check("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            sel   = vecs[v].big;
            lat   = vecs[v].lat;
            noise = vecs[v].noise;
            for (int i = 0; i < 256; i++) begin
                case (vecs[v].kind)
                    0:       mem[i] = (i < 4) ? 8'((i + 1) * 16) : 8'h00;
                    1:       mem[i] = 8'(i);
                    default: mem[i] = 8'($urandom);
                endcase
            end
            build_exp(vecs[v].big ? 256 : 4);
            run_frame(vecs[v].big ? 256 : 4, vecs[v].mid_start, vecs[v].fin_start,
                      vecs[v].exp_bytes, vecs[v].exp_last);
            repeat (3) @(negedge clk);
        end

        // Reset after the third data byte, then a clean frame.
        sel = 1'b0;
        lat = 20;
        noise = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 8'((i + 1) * 16);
        base  = got_q.size();
        fbase = fin_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (got_q.size() - base < 6 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("reset_setup_timeout", 32'(guard < 2000), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_addr", addr_s, 0);
        check("midrst_data", data_s, 0);
        check("midrst_send", send_s, 0);
        check("midrst_busy", busy_s, 0);
        check("midrst_fin", fin_s, 0);
        sz = got_q.size();
        repeat (40) @(negedge clk);
        check("post_reset_sends", got_q.size() - sz, 0);
        check("post_reset_finished", fin_cnt - fbase, 0);
        build_exp(4);
        run_frame(4, 1'b0, 1'b0, N4, L4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
